// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types and defaults for the collision pair scheduler
package collision_pkg;

   localparam int COORD_W = 8;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] z;
   } point_t;

   typedef struct packed {
      point_t p;
      point_t q;
   } segment_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/pair_index_gen.sv
// rtl/pair_index_gen.sv - i<j pair walker; COLLISION_SKIP_ADJ_EN skips pairs with j == i+1
module pair_index_gen #(
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic             advance,
   input  logic [CNT_W-1:0] count,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j,
   output logic             last,
   output logic             empty
);

`ifdef COLLISION_SKIP_ADJ_EN
   // adjacent segments share an endpoint, so the first useful partner is i+2
   localparam int GAP = 2;
`else
   localparam int GAP = 1;
`endif

   // counters carry CNT_W bits so the post-last advance can wrap harmlessly
   logic [CNT_W-1:0] ii;
   logic [CNT_W-1:0] jj;

   // step j along the row, then move to the next row starting at i+GAP
   always_ff @(posedge clk) begin
      if (reset || init) begin
         ii <= '0;
         jj <= CNT_W'(GAP);
      end else if (advance) begin
         if (jj < count - CNT_W'(1)) begin
            jj <= jj + CNT_W'(1);
         end else begin
            ii <= ii + CNT_W'(1);
            jj <= ii + CNT_W'(1 + GAP);
         end
      end
   end

   assign i     = ii[IDX_W-1:0];
   assign j     = jj[IDX_W-1:0];
   assign last  = (ii == count - CNT_W'(1 + GAP)) && (jj == count - CNT_W'(1));
   assign empty = (count < CNT_W'(GAP + 1));

endmodule

// File: rtl/collision_pair_scheduler.sv
// rtl/collision_pair_scheduler.sv - buffers segments and issues every pair to a collision detector (option: COLLISION_SKIP_ADJ_EN)
module collision_pair_scheduler #(
   parameter int COORD_W = collision_pkg::COORD_W,
   parameter int DEPTH   = 8,
   parameter int IDX_W   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 seg_valid,
   output logic                 seg_ready,
   input  logic [3*COORD_W-1:0] seg_p,
   input  logic [3*COORD_W-1:0] seg_q,
   input  logic                 start,
   output logic                 busy,
   output logic                 pair_valid,
   input  logic                 pair_ready,
   output logic [3*COORD_W-1:0] pair_p1,
   output logic [3*COORD_W-1:0] pair_q1,
   output logic [3*COORD_W-1:0] pair_p2,
   output logic [3*COORD_W-1:0] pair_q2,
   input  logic                 hit_valid,
   input  logic                 hit,
   output logic                 done,
   output logic                 collision,
   output logic [IDX_W-1:0]     first_a,
   output logic [IDX_W-1:0]     first_b,
   output logic [7:0]           hit_count
);

   import collision_pkg::*;

   localparam int SEG_W = 3 * COORD_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [SEG_W-1:0] p_mem [DEPTH];
   logic [SEG_W-1:0] q_mem [DEPTH];
   logic [CNT_W-1:0] count;

   sched_state_t state;
   sched_state_t state_nx;

   logic             wr_en;
   logic             init_pairs;
   logic             advance_pairs;
   logic [IDX_W-1:0] idx_i;
   logic [IDX_W-1:0] idx_j;
   logic             pair_last;
   logic             pair_empty;

   pair_index_gen #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_index (
      .clk     (clk),
      .reset   (reset),
      .init    (init_pairs),
      .advance (advance_pairs),
      .count   (count),
      .i       (idx_i),
      .j       (idx_j),
      .last    (pair_last),
      .empty   (pair_empty)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_nx;
      end
   end

   // next state and handshake outputs; start wins over a same-cycle segment write
   always_comb begin
      state_nx      = state;
      seg_ready     = 1'b0;
      wr_en         = 1'b0;
      busy          = 1'b0;
      pair_valid    = 1'b0;
      done          = 1'b0;
      init_pairs    = 1'b0;
      advance_pairs = 1'b0;
      case (state)
         LOAD: begin
            seg_ready = (count < CNT_W'(DEPTH)) && !start;
            wr_en     = seg_valid && seg_ready;
            if (start) begin
               init_pairs = 1'b1;
               state_nx   = pair_empty ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            busy       = 1'b1;
            pair_valid = 1'b1;
            if (pair_ready) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (hit_valid) begin
               advance_pairs = 1'b1;
               state_nx      = pair_last ? FIN : ISSUE;
            end
         end
         FIN: begin
            done     = 1'b1;
            state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   // segment buffer; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (wr_en) begin
         p_mem[count[IDX_W-1:0]] <= seg_p;
         q_mem[count[IDX_W-1:0]] <= seg_q;
      end
   end

   // fill level, emptied once a scan completes
   always_ff @(posedge clk) begin
      if (reset || state == FIN) begin
         count <= '0;
      end else if (wr_en) begin
         count <= count + CNT_W'(1);
      end
   end

   // scan summary: cleared on start, updated on each result in WAIT
   always_ff @(posedge clk) begin
      if (reset || (state == LOAD && start)) begin
         collision <= 1'b0;
         first_a   <= '0;
         first_b   <= '0;
         hit_count <= '0;
      end else if (state == WAIT && hit_valid && hit) begin
         if (hit_count != 8'hFF) begin
            hit_count <= hit_count + 8'd1;
         end
         if (!collision) begin
            collision <= 1'b1;
            first_a   <= idx_i;
            first_b   <= idx_j;
         end
      end
   end

   // pair bus reads zero whenever no pair is being offered
   assign pair_p1 = pair_valid ? p_mem[idx_i] : '0;
   assign pair_q1 = pair_valid ? q_mem[idx_i] : '0;
   assign pair_p2 = pair_valid ? p_mem[idx_j] : '0;
   assign pair_q2 = pair_valid ? q_mem[idx_j] : '0;

endmodule
